// File: rtl/trap_sequencer.sv
// Trap sequencer: turns fetch/execute exceptions and MRET into flushes, PC redirects and CSR trap writes.
// Latency: trap flush N+1, redirect N+2; MRET redirect N+1. Optional macro TRAP_MTVAL_EN adds the mtval capture.

`ifndef XLEN_32b
`define XLEN_32b 2'd1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif
`ifndef USER
`define USER 2'b00
`endif
`ifndef MACHINE
`define MACHINE 2'b11
`endif
`ifndef E_INSTR_MISALIGNED
`define E_INSTR_MISALIGNED   4'd0
`define E_INSTR_ACCESS_FAULT 4'd1
`define E_ILLEGAL_INSTR      4'd2
`define E_BREAKPOINT         4'd3
`define E_LOAD_MISALIGNED    4'd4
`define E_LOAD_ACCESS_FAULT  4'd5
`define E_STORE_MISALIGNED   4'd6
`define E_STORE_ACCESS_FAULT 4'd7
`define E_ECALL              4'd8
`define NO_E                 4'hF
`endif

module trap_sequencer #(
    parameter logic [1:0] XLEN = `XLEN_64b,
    localparam int W = 1 << (int'(XLEN) + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_exception_code_f,
    input  logic [3:0]   i_exception_code_e,
    input  logic [W-1:0] i_pc_f,
    input  logic [W-1:0] i_pc_e,
    input  logic [W-1:0] i_alu_out_e,
    input  logic         i_mret_e,
    input  logic [W-1:0] i_mtvec,
    input  logic [W-1:0] i_mepc,
    input  logic [1:0]   i_mstatus_mpp,
    output logic         o_flush_f,
    output logic         o_flush_d,
    output logic         o_flush_e,
    output logic         o_redirect_valid,
    output logic [W-1:0] o_redirect_pc,
    output logic         o_trap_we,
    output logic [W-1:0] o_mepc,
    output logic [W-1:0] o_mcause,
    output logic [W-1:0] o_mtval,
    output logic         o_mret_we,
    output logic [1:0]   o_current_privilege,
    output logic         o_disable_exceptions_1cc,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_REDIRECT,
        S_MRET
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   priv_q, priv_d;
    logic [W-1:0] mepc_q, mepc_d;
    logic [W-1:0] mcause_q, mcause_d;

    logic         exc_e_vld;
    logic         exc_f_vld;
    logic [3:0]   cap_code;
    logic [W-1:0] cap_pc;
    logic [W-1:0] cap_cause;

    // Execute-stage faults are older in program order, so they take priority.
    assign exc_e_vld = (i_exception_code_e != `NO_E);
    assign exc_f_vld = (i_exception_code_f != `NO_E);
    assign cap_code  = exc_e_vld ? i_exception_code_e : i_exception_code_f;
    assign cap_pc    = exc_e_vld ? i_pc_e : i_pc_f;
    assign cap_cause = (cap_code == `E_ECALL) ? (W'(8) + W'(priv_q)) : W'(cap_code);

`ifdef TRAP_MTVAL_EN
    logic [W-1:0] mtval_q, mtval_d;
    logic [W-1:0] cap_tval;

    always_comb begin
        case (cap_code)
            `E_LOAD_MISALIGNED, `E_LOAD_ACCESS_FAULT,
            `E_STORE_MISALIGNED, `E_STORE_ACCESS_FAULT: cap_tval = i_alu_out_e;
            `E_INSTR_MISALIGNED:                        cap_tval = cap_pc;
            default:                                    cap_tval = '0;
        endcase
    end

    always_comb begin
        mtval_d = mtval_q;
        if ((state_q == S_IDLE) && (exc_e_vld || exc_f_vld)) begin
            mtval_d = cap_tval;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtval_q <= '0;
        end else begin
            mtval_q <= mtval_d;
        end
    end

    assign o_mtval = (state_q == S_TRAP) ? mtval_q : '0;
`else
    logic unused_alu_out;
    assign unused_alu_out = ^i_alu_out_e;
    assign o_mtval        = '0;
`endif

    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^i_mtvec[1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            priv_q   <= `MACHINE;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            priv_q   <= priv_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

    always_comb begin
        state_d                  = state_q;
        priv_d                   = priv_q;
        mepc_d                   = mepc_q;
        mcause_d                 = mcause_q;
        o_flush_f                = 1'b0;
        o_flush_d                = 1'b0;
        o_flush_e                = 1'b0;
        o_redirect_valid         = 1'b0;
        o_redirect_pc            = '0;
        o_trap_we                = 1'b0;
        o_mepc                   = '0;
        o_mcause                 = '0;
        o_mret_we                = 1'b0;
        o_disable_exceptions_1cc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exc_e_vld || exc_f_vld) begin
                    mepc_d   = cap_pc;
                    mcause_d = cap_cause;
                    state_d  = S_TRAP;
                end else if (i_mret_e) begin
                    state_d = S_MRET;
                end
            end
            S_TRAP: begin
                o_flush_f = 1'b1;
                o_flush_d = 1'b1;
                o_flush_e = 1'b1;
                o_trap_we = 1'b1;
                o_mepc    = mepc_q;
                o_mcause  = mcause_q;
                priv_d    = `MACHINE;
                state_d   = S_REDIRECT;
            end
            S_REDIRECT: begin
                // The instruction arriving at the handler must not re-trap on stale state.
                o_redirect_valid         = 1'b1;
                o_redirect_pc            = {i_mtvec[W-1:2], 2'b00};
                o_disable_exceptions_1cc = 1'b1;
                state_d                  = S_IDLE;
            end
            S_MRET: begin
                o_flush_f        = 1'b1;
                o_flush_d        = 1'b1;
                o_flush_e        = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = i_mepc;
                o_mret_we        = 1'b1;
                priv_d           = i_mstatus_mpp;
                state_d          = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_current_privilege = priv_q;
    assign o_busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of the trap/MRET sequences.

`ifndef USER
`define USER 2'b00
`endif
`ifndef MACHINE
`define MACHINE 2'b11
`endif
`ifndef E_INSTR_MISALIGNED
`define E_INSTR_MISALIGNED   4'd0
`define E_INSTR_ACCESS_FAULT 4'd1
`define E_ILLEGAL_INSTR      4'd2
`define E_BREAKPOINT         4'd3
`define E_LOAD_MISALIGNED    4'd4
`define E_LOAD_ACCESS_FAULT  4'd5
`define E_STORE_MISALIGNED   4'd6
`define E_STORE_ACCESS_FAULT 4'd7
`define E_ECALL              4'd8
`define NO_E                 4'hF
`endif

module tb_trap_sequencer;
    localparam int W = 64;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [3:0]   i_exception_code_f = `NO_E;
    logic [3:0]   i_exception_code_e = `NO_E;
    logic [W-1:0] i_pc_f = '0;
    logic [W-1:0] i_pc_e = '0;
    logic [W-1:0] i_alu_out_e = '0;
    logic         i_mret_e = 1'b0;
    logic [W-1:0] i_mtvec = '0;
    logic [W-1:0] i_mepc = '0;
    logic [1:0]   i_mstatus_mpp = `USER;
    logic         o_flush_f, o_flush_d, o_flush_e;
    logic         o_redirect_valid;
    logic [W-1:0] o_redirect_pc;
    logic         o_trap_we;
    logic [W-1:0] o_mepc, o_mcause, o_mtval;
    logic         o_mret_we;
    logic [1:0]   o_current_privilege;
    logic         o_disable_exceptions_1cc;
    logic         o_busy;

    trap_sequencer dut (
        .i_clk                   (i_clk),
        .i_rst_n                 (i_rst_n),
        .i_exception_code_f      (i_exception_code_f),
        .i_exception_code_e      (i_exception_code_e),
        .i_pc_f                  (i_pc_f),
        .i_pc_e                  (i_pc_e),
        .i_alu_out_e             (i_alu_out_e),
        .i_mret_e                (i_mret_e),
        .i_mtvec                 (i_mtvec),
        .i_mepc                  (i_mepc),
        .i_mstatus_mpp           (i_mstatus_mpp),
        .o_flush_f               (o_flush_f),
        .o_flush_d               (o_flush_d),
        .o_flush_e               (o_flush_e),
        .o_redirect_valid        (o_redirect_valid),
        .o_redirect_pc           (o_redirect_pc),
        .o_trap_we               (o_trap_we),
        .o_mepc                  (o_mepc),
        .o_mcause                (o_mcause),
        .o_mtval                 (o_mtval),
        .o_mret_we               (o_mret_we),
        .o_current_privilege     (o_current_privilege),
        .o_disable_exceptions_1cc(o_disable_exceptions_1cc),
        .o_busy                  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Model: the cycle kind currently expected plus the kinds still owed by an accepted event.
    typedef enum int {K_IDLE, K_TRAP, K_REDIR, K_MRET} kind_t;
    kind_t        cur;
    kind_t        plan[$];
    logic [1:0]   m_priv;
    logic [W-1:0] m_epc, m_cause, m_tval;

    function automatic void model_reset();
        cur = K_IDLE;
        plan.delete();
        m_priv  = `MACHINE;
        m_epc   = '0;
        m_cause = '0;
        m_tval  = '0;
    endfunction

    function automatic void capture(input logic [3:0] code, input logic [W-1:0] pc);
        m_cause = (code == `E_ECALL) ? W'(8 + int'(m_priv)) : W'(code);
        m_epc   = pc;
`ifdef TRAP_MTVAL_EN
        if (code inside {`E_LOAD_MISALIGNED, `E_LOAD_ACCESS_FAULT, `E_STORE_MISALIGNED, `E_STORE_ACCESS_FAULT})
            m_tval = i_alu_out_e;
        else if (code == `E_INSTR_MISALIGNED)
            m_tval = pc;
        else
            m_tval = '0;
`else
        m_tval = '0;
`endif
        cur = K_TRAP;
        plan.push_back(K_REDIR);
    endfunction

    function automatic void model_edge();
        if (cur != K_IDLE) begin
            if (cur == K_TRAP) m_priv = `MACHINE;
            if (cur == K_MRET) m_priv = i_mstatus_mpp;
            cur = (plan.size() > 0) ? plan.pop_front() : K_IDLE;
        end else if (i_exception_code_e != `NO_E) begin
            capture(i_exception_code_e, i_pc_e);
        end else if (i_exception_code_f != `NO_E) begin
            capture(i_exception_code_f, i_pc_f);
        end else if (i_mret_e) begin
            cur = K_MRET;
        end
    endfunction

    task automatic compare_all();
        logic         flush, trap, redir;
        logic [W-1:0] rpc;
        flush = (cur == K_TRAP) || (cur == K_MRET);
        trap  = (cur == K_TRAP);
        redir = (cur == K_REDIR) || (cur == K_MRET);
        rpc   = (cur == K_REDIR) ? (i_mtvec & ~W'(3)) : (cur == K_MRET) ? i_mepc : '0;
        chk("flush_f", W'(o_flush_f), W'(flush));
        chk("flush_d", W'(o_flush_d), W'(flush));
        chk("flush_e", W'(o_flush_e), W'(flush));
        chk("trap_we", W'(o_trap_we), W'(trap));
        chk("mepc", o_mepc, trap ? m_epc : '0);
        chk("mcause", o_mcause, trap ? m_cause : '0);
        chk("mtval", o_mtval, trap ? m_tval : '0);
        chk("redirect_valid", W'(o_redirect_valid), W'(redir));
        chk("redirect_pc", o_redirect_pc, rpc);
        chk("mret_we", W'(o_mret_we), W'(cur == K_MRET));
        chk("disable_exc", W'(o_disable_exceptions_1cc), W'(cur == K_REDIR));
        chk("busy", W'(o_busy), W'(cur != K_IDLE));
        chk("privilege", W'(o_current_privilege), W'(m_priv));
    endtask

    always @(posedge i_clk) begin
        if (!i_rst_n) model_reset();
        else model_edge();
        #2;
        compare_all();
    end

    task automatic clear_inputs();
        i_exception_code_e = `NO_E;
        i_exception_code_f = `NO_E;
        i_mret_e           = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge i_clk);
        #3;
    endtask

    function automatic logic [3:0] rand_code();
        if ($urandom_range(0, 99) < 12) return 4'($urandom_range(0, 8));
        return `NO_E;
    endfunction

    initial begin
        repeat (3) @(negedge i_clk);
        chk("reset_busy", W'(o_busy), W'(0));
        chk("reset_priv", W'(o_current_privilege), W'(`MACHINE));
        i_rst_n = 1'b1;

        // MRET back to user mode
        @(negedge i_clk);
        i_mret_e = 1'b1; i_mepc = 'h400; i_mstatus_mpp = `USER;
        after_edge();
        chk("mret_pc", o_redirect_pc, 'h400);
        chk("mret_we", W'(o_mret_we), W'(1));
        @(negedge i_clk);
        clear_inputs();
        after_edge();
        chk("mret_priv_user", W'(o_current_privilege), W'(`USER));

        // ECALL from user mode
        @(negedge i_clk);
        i_exception_code_e = `E_ECALL; i_pc_e = 'h100; i_mtvec = 'h801;
        after_edge();
        chk("ecall_trap_we", W'(o_trap_we), W'(1));
        chk("ecall_mcause", o_mcause, W'(8));
        chk("ecall_mepc", o_mepc, 'h100);
        @(negedge i_clk);
        clear_inputs();
        after_edge();
        chk("ecall_redirect_pc", o_redirect_pc, 'h800);
        chk("ecall_priv_m", W'(o_current_privilege), W'(`MACHINE));
        after_edge();

        // Execute-stage fault wins over fetch-stage fault
        @(negedge i_clk);
        i_exception_code_f = `E_ILLEGAL_INSTR; i_exception_code_e = `E_LOAD_ACCESS_FAULT;
        i_alu_out_e = 'h2004; i_pc_e = 'h300; i_pc_f = 'h500;
        after_edge();
        chk("prio_mcause", o_mcause, W'(`E_LOAD_ACCESS_FAULT));
        chk("prio_mepc", o_mepc, 'h300);
`ifdef TRAP_MTVAL_EN
        chk("prio_mtval", o_mtval, 'h2004);
`else
        chk("prio_mtval", o_mtval, '0);
`endif
        @(negedge i_clk);
        clear_inputs();
        repeat (2) after_edge();

        // Exception beats a simultaneous MRET
        @(negedge i_clk);
        i_mret_e = 1'b1; i_exception_code_e = `E_ECALL;
        after_edge();
        chk("both_trap_we", W'(o_trap_we), W'(1));
        chk("both_mret_we", W'(o_mret_we), W'(0));
        chk("both_mcause_m", o_mcause, W'(11));
        @(negedge i_clk);
        clear_inputs();
        after_edge();
        chk("both_mret_we2", W'(o_mret_we), W'(0));
        after_edge();

        // New requests while busy are ignored
        @(negedge i_clk);
        i_exception_code_e = `E_ILLEGAL_INSTR; i_pc_e = 'h600;
        after_edge();
        @(negedge i_clk);
        i_exception_code_e = `E_STORE_MISALIGNED; i_mret_e = 1'b1;
        after_edge();
        chk("busy_in_redirect", W'(o_busy), W'(1));
        after_edge();
        chk("busy_falls", W'(o_busy), W'(0));
        @(negedge i_clk);
        clear_inputs();
        after_edge();
        chk("busy_stays_low", W'(o_busy), W'(0));

        // Reset in the middle of a trap
        @(negedge i_clk);
        i_exception_code_f = `E_BREAKPOINT;
        @(negedge i_clk);
        clear_inputs();
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_trap_we", W'(o_trap_we), W'(0));
        chk("rst_flush_f", W'(o_flush_f), W'(0));
        chk("rst_priv", W'(o_current_privilege), W'(`MACHINE));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            after_edge();
            chk("post_rst_redirect", W'(o_redirect_valid), W'(0));
            chk("post_rst_trap_we", W'(o_trap_we), W'(0));
        end

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            i_exception_code_e = rand_code();
            i_exception_code_f = rand_code();
            i_mret_e           = ($urandom_range(0, 99) < 10);
            i_pc_e             = {$urandom, $urandom};
            i_pc_f             = {$urandom, $urandom};
            i_alu_out_e        = {$urandom, $urandom};
            i_mtvec            = {$urandom, $urandom};
            i_mepc             = {$urandom, $urandom};
            i_mstatus_mpp      = 2'($urandom_range(0, 3));
        end
        @(negedge i_clk);
        clear_inputs();
        repeat (4) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
